// File: rtl/delay_ctrl_if.sv
// Configuration and sample-stream bundle for delay_ctrl.
// The master drives configuration and samples; the slave (delay_ctrl) returns delayed samples.
interface delay_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DELAY  = 64
);
    localparam int AW = $clog2(MAX_DELAY);

    logic [AW:0]           cfg_delay;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic                  cfg_err;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [1:0]            state;

    modport master (
        output cfg_delay, cfg_valid, din, din_valid,
        input  cfg_ready, cfg_err, dout, dout_valid, state
    );

    modport slave (
        input  cfg_delay, cfg_valid, din, din_valid,
        output cfg_ready, cfg_err, dout, dout_valid, state
    );
endinterface

// File: rtl/delay_ctrl.sv
// Programmable sample delay line: a circular buffer read D valid samples behind the write
// pointer, with a fill phase after every (re)configuration so no stale data is emitted.
module delay_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DELAY  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    delay_ctrl_if.slave  bus
);
    localparam int             AW    = $clog2(MAX_DELAY);
    localparam logic [AW:0]    MAX_D = (AW+1)'(MAX_DELAY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_addr;
    logic [AW:0]           fill_cnt;
    logic [AW:0]           fill_next;
    logic [AW:0]           delay_q;
    logic [AW:0]           delay_clamped;
    logic                  clamp_hit;
    logic                  cfg_ready;
    logic                  handshake;
    logic                  wr_en;
    logic                  rd_en;
    logic                  fill_done;
    logic [DATA_WIDTH-1:0] mem [MAX_DELAY];
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;
    logic                  cfg_err_q;

    // Requested delay is clamped into [1, MAX_DELAY]; an out-of-range request is flagged.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        delay_clamped = bus.cfg_delay;
        clamp_hit     = 1'b0;
        if (bus.cfg_delay == '0) begin
            delay_clamped = (AW+1)'(1);
            clamp_hit     = 1'b1;
        end else if (bus.cfg_delay > MAX_D) begin
            delay_clamped = MAX_D;
            clamp_hit     = 1'b1;
        end
    end

    assign cfg_ready = (state_q != FILL);
    assign handshake = bus.cfg_valid && cfg_ready;
    assign wr_en     = bus.din_valid && (state_q != IDLE);
    assign rd_en     = bus.din_valid && (state_q == RUN);
    assign rd_addr   = wr_ptr - delay_q[AW-1:0];
    assign fill_next = fill_cnt + (AW+1)'(1);
    assign fill_done = (state_q == FILL) && bus.din_valid && (fill_next == delay_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = FILL;
            FILL:    if (fill_done) state_d = RUN;
            RUN:     if (handshake) state_d = FILL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= IDLE;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            delay_q      <= (AW+1)'(1);
            cfg_err_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            cfg_err_q    <= handshake && clamp_hit;
            dout_valid_q <= rd_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // A handshake in RUN still lets this cycle's sample through under the old delay.
            if (handshake) begin
                delay_q  <= delay_clamped;
                fill_cnt <= '0;
            end else if ((state_q == FILL) && bus.din_valid && (fill_cnt != delay_q)) begin
                fill_cnt <= fill_next;
            end
            if (rd_en) begin
                dout_q <= mem[rd_addr];
            end
        end
    end

    // NOTE: the sample buffer has no reset so it maps onto block RAM; the fill phase guarantees
    // every location read was written after the last configuration.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    assign bus.cfg_ready  = cfg_ready;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: a directed vector table, hand-written corner sequences,
// and randomized traffic compared against a sample-history reference model.
module tb_delay_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic sel;

    always #5 clk = ~clk;

    delay_ctrl_if #(.DATA_WIDTH(32), .MAX_DELAY(64)) if64 ();
    delay_ctrl_if #(.DATA_WIDTH(32), .MAX_DELAY(8))  if8 ();

    delay_ctrl #(.DATA_WIDTH(32), .MAX_DELAY(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
    delay_ctrl #(.DATA_WIDTH(32), .MAX_DELAY(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    logic [31:0] a_dout;
    logic        a_valid, a_err, a_ready;
    logic [1:0]  a_state;

    always_comb begin
        a_dout  = sel ? if8.dout       : if64.dout;
        a_valid = sel ? if8.dout_valid : if64.dout_valid;
        a_err   = sel ? if8.cfg_err    : if64.cfg_err;
        a_ready = sel ? if8.cfg_ready  : if64.cfg_ready;
        a_state = sel ? if8.state      : if64.state;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive(input logic cv, input int cd, input logic dv, input logic [31:0] dd);
        if64.cfg_valid = !sel && cv;
        if64.cfg_delay = 7'(cd);
        if64.din_valid = !sel && dv;
        if64.din       = dd;
        if8.cfg_valid  = sel && cv;
        if8.cfg_delay  = 4'(cd);
        if8.din_valid  = sel && dv;
        if8.din        = dd;
    endtask

    // Reference model: mode 0=idle,1=fill,2=run; history of every written sample.
    int          maxd;
    int          m_mode, m_d, m_cnt;
    logic [31:0] m_dout;
    logic        m_valid, m_err;
    logic [31:0] hist[$];

    task automatic model_reset();
        maxd    = sel ? 8 : 64;
        m_mode  = 0;
        m_d     = 1;
        m_cnt   = 0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        hist.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 0, 1'b0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step_model(input logic cv, input int cd, input logic dv, input logic [31:0] dd);
        int  cdw;
        bit  hs;
        @(negedge clk);
        drive(cv, cd, dv, dd);
        check("cfg_ready", {31'd0, a_ready}, {31'd0, m_mode != 1});
        check("state_pre", {30'd0, a_state}, m_mode);
        cdw     = cd & (2 * maxd - 1);
        hs      = cv && (m_mode != 1);
        m_valid = (m_mode == 2) && dv;
        if (m_valid) m_dout = hist[hist.size() - m_d];
        m_err   = hs && (cdw == 0 || cdw > maxd);
        if (m_mode != 0 && dv) begin
            hist.push_back(dd);
            if (hist.size() > maxd) void'(hist.pop_front());
        end
        if (m_mode == 1 && dv) begin
            m_cnt++;
            if (m_cnt == m_d) m_mode = 2;
        end
        if (hs) begin
            m_d    = (cdw == 0) ? 1 : (cdw > maxd) ? maxd : cdw;
            m_cnt  = 0;
            m_mode = 1;
        end
        @(posedge clk);
        #1;
        check("dout_valid", {31'd0, a_valid}, {31'd0, m_valid});
        check("dout", a_dout, m_dout);
        check("cfg_err", {31'd0, a_err}, {31'd0, m_err});
        check("state", {30'd0, a_state}, m_mode);
    endtask

    typedef struct {
        logic        cv;
        int          cd;
        logic        dv;
        logic [31:0] dd;
        logic        ev;
        logic [31:0] ed;
        logic        eerr;
        logic [1:0]  est;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Directed vectors: D=4 with a counting stream, a gap, then a clamped reconfig from RUN.
        vecs[0] = '{1'b1, 4, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 2'd1};
        for (int k = 1; k <= 8; k++)
            vecs[k] = '{1'b0, 0, 1'b1, 32'(k), k >= 5, (k >= 5) ? 32'(k - 4) : 32'd0,
                        1'b0, (k >= 4) ? 2'd2 : 2'd1};
        vecs[9]  = '{1'b0, 0, 1'b0, 32'd0, 1'b0, 32'd4, 1'b0, 2'd2};
        vecs[10] = '{1'b1, 0, 1'b1, 32'd9, 1'b1, 32'd5, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 0, 1'b0, 32'd0, 1'b0, 32'd5, 1'b0, 2'd1};

        sel   = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {30'd0, a_state}, 0);
        check("rst_ready", {31'd0, a_ready}, 1);
        check("rst_valid", {31'd0, a_valid}, 0);
        check("rst_dout", a_dout, 0);
        check("rst_err", {31'd0, a_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].cv, vecs[i].cd, vecs[i].dv, vecs[i].dd);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, a_valid}, {31'd0, vecs[i].ev});
            check($sformatf("vec%0d_dout", i), a_dout, vecs[i].ed);
            check($sformatf("vec%0d_err", i), {31'd0, a_err}, {31'd0, vecs[i].eerr});
            check($sformatf("vec%0d_state", i), {30'd0, a_state}, {30'd0, vecs[i].est});
        end

        // D=3 with alternating din_valid.
        do_reset();
        step_model(1'b1, 3, 1'b0, '0);
        for (int i = 0; i < 16; i++) step_model(1'b0, 0, (i % 2) == 0, 32'(100 + i));

        // Clamp low then clamp high; D=64 with counting data.
        do_reset();
        step_model(1'b1, 0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step_model(1'b0, 0, 1'b1, 32'(50 + i));
        step_model(1'b1, 69, 1'b0, '0);
        for (int i = 0; i < 80; i++) begin
            step_model(1'b0, 0, 1'b1, 32'(1000 + i));
            if (i >= 64) check("d64_dout", a_dout, 32'(1000 + i - 64));
        end

        // Reconfigure from RUN at D=2 to D=5; cfg_valid held during FILL must be refused.
        do_reset();
        step_model(1'b1, 2, 1'b0, '0);
        for (int i = 0; i < 6; i++) step_model(1'b0, 0, 1'b1, 32'(300 + i));
        step_model(1'b1, 5, 1'b1, 32'd399);
        for (int j = 0; j < 10; j++) begin
            step_model(j < 5, 1, 1'b1, 32'(200 + j));
            if (j >= 5) check("d5_dout", a_dout, 32'(200 + j - 5));
        end

        // Asynchronous reset between edges while RUN is producing output.
        step_model(1'b0, 0, 1'b1, 32'd777);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, a_valid}, 0);
        check("async_state", {30'd0, a_state}, 0);
        check("async_ready", {31'd0, a_ready}, 1);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, '0);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step_model(1'b0, 0, 1'b1, 32'(500 + i));

        // Pointer wrap on the 8-deep instance at D=7.
        sel = 1'b1;
        do_reset();
        step_model(1'b1, 7, 1'b0, '0);
        for (int i = 0; i < 100; i++) step_model(1'b0, 0, ($urandom % 4) != 0, $urandom);

        // Random traffic with occasional reconfiguration.
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++)
            step_model(($urandom % 20) == 0, int'($urandom % 72), ($urandom % 3) != 0, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/delay_ctrl.md
DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, defining the sample width in bits.
REQ-002 The block SHALL have parameter MAX_DELAY, default 64, a power of two from 2 to 4096, defining buffer depth and maximum delay in samples.
REQ-003 The block SHALL have localparam AW = log2(MAX_DELAY), the pointer width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port cfg_delay, input, AW+1 bits: requested delay in accepted samples.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: cfg_delay is offered.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-009 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an accepted cfg_delay was clamped.
REQ-010 The block SHALL have port din, input, DATA_WIDTH bits: input sample.
REQ-011 The block SHALL have port din_valid, input, 1 bit: qualifies din, with no backpressure.
REQ-012 The block SHALL have port dout, output, DATA_WIDTH bits: delayed sample, registered.
REQ-013 The block SHALL have port dout_valid, output, 1 bit: qualifies dout.
REQ-014 The block SHALL have port state, output, 2 bits: IDLE=0, FILL=1, RUN=2; value 3 is unused.

Function
REQ-015 The block SHALL store samples in a MAX_DELAY-entry circular buffer with AW-bit write pointer wr_ptr, incremented modulo MAX_DELAY on each cycle with din_valid=1 while state is FILL or RUN.
REQ-016 The block SHALL ignore din_valid in IDLE: no write, no pointer move, dout_valid=0.
REQ-017 The block SHALL complete a configuration handshake on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-018 The block SHALL drive cfg_ready=1 in IDLE and RUN, and 0 in FILL.
REQ-019 On handshake the block SHALL latch D = cfg_delay clamped to [1, MAX_DELAY], and SHALL pulse cfg_err on the next cycle if clamping occurred (cfg_delay=0 or cfg_delay>MAX_DELAY).
REQ-020 On handshake the block SHALL clear fill counter fill_cnt to 0 and enter FILL on the next cycle, from either IDLE or RUN.
REQ-021 The block SHALL NOT clear buffer contents or wr_ptr on reconfiguration.
REQ-022 A din_valid sample presented on the handshake cycle SHALL be processed under the previous state and delay.
REQ-023 In FILL, each din_valid SHALL write din and increment fill_cnt, with dout_valid held at 0.
REQ-024 When the D-th sample since the handshake is written, the block SHALL move to RUN on the next cycle.
REQ-025 In RUN, on each cycle with din_valid=1, the block SHALL read entry (wr_ptr - D) mod MAX_DELAY and write din at wr_ptr in the same cycle.
REQ-026 The read SHALL return the old contents (read-before-write), so D=MAX_DELAY works.
REQ-027 On the cycle after such a RUN-state din_valid cycle, the block SHALL present the read value on dout with dout_valid=1.
REQ-028 Latency SHALL be exactly one clock from din_valid to dout_valid; the dout sample SHALL be the one accepted D valid-samples earlier.
REQ-029 Gaps in din_valid SHALL NOT advance the delay; dout_valid SHALL be 0 on every cycle not following a RUN-state din_valid.
REQ-030 dout SHALL hold its last value while dout_valid=0.
REQ-031 fill_cnt SHALL be AW+1 bits wide and SHALL NOT wrap; it saturates at D.
REQ-032 The buffer SHALL be inferable as simple dual-port RAM: one write port and one read port, with the registered read as the only read path.

Reset
REQ-033 When rst_n=0, the block SHALL asynchronously force state=IDLE, wr_ptr=0, fill_cnt=0, D=1, dout=0, dout_valid=0, and cfg_err=0.
REQ-034 During reset, cfg_ready SHALL equal 1, since it is decoded from IDLE.
REQ-035 Buffer contents SHALL NOT be reset.
REQ-036 Deassertion of rst_n SHALL be followed by IDLE operation on the first rising edge.
REQ-037 Reset asserted mid-FILL or mid-RUN SHALL abort the operation; no dout_valid SHALL occur until a new handshake and fill complete.

Verification
REQ-038 The bench SHALL cover this scenario: reset, cfg_delay=4, then continuous din=1,2,3,... -> dout_valid first high on the cycle after din=5, with dout=1, then 2, 3, ... every cycle; state=1 for 4 samples, then 2.
REQ-039 The bench SHALL cover this scenario: D=3 with din_valid toggling 1,0,1,0 -> dout_valid pattern mirrors din_valid delayed one cycle after fill, and dout equals the sample three valid inputs earlier.
REQ-040 The bench SHALL cover this scenario: cfg_delay=0 -> cfg_err pulse and D=1; cfg_delay=MAX_DELAY+5 -> cfg_err pulse and D=MAX_DELAY; at MAX_DELAY=64, with din counting, dout = din-64.
REQ-041 The bench SHALL cover this scenario: in RUN at D=2, a handshake with cfg_delay=5 -> cfg_ready=0 and dout_valid=0 for the next 5 valid samples, then dout = the sample 5 valid samples earlier; cfg_valid asserted during FILL is not accepted.
REQ-042 The bench SHALL cover this scenario: rst_n pulsed low asynchronously mid-RUN (between edges) -> dout_valid and state drop to 0 immediately; din_valid after release gives no output until reconfigured.
REQ-043 The bench SHALL cover this scenario: wr_ptr wrap with D=7, MAX_DELAY=8, over 100 samples -> all outputs match the reference model with no glitch at the wrap.
